// File: rtl/team_07_wb_master_arbiter.sv
// Round-robin arbiter that shares one classic Wishbone master port between
// NUM_REQ internal requesters. It runs one single-beat cycle per grant and
// returns an error response if the slave never acknowledges.
//
//  state  | meaning
//  IDLE   | no transaction; pick the next requester round-robin from ptr
//  BUS    | CYC/STB asserted, waiting for ACK_I or the hang timeout
//  RESP   | one-cycle rsp_valid_o strobe to the owning requester
module team_07_wb_master_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   input  logic [NUM_REQ-1:0]      req_we_i,
   input  logic [32*NUM_REQ-1:0]   req_adr_i,
   input  logic [32*NUM_REQ-1:0]   req_dat_i,
   input  logic [4*NUM_REQ-1:0]    req_sel_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   output logic [NUM_REQ-1:0]      rsp_valid_o,
   output logic [31:0]             rsp_dat_o,
   output logic                    rsp_err_o,
   output logic                    busy_o,
   output logic [31:0]             ADR_O,
   output logic [31:0]             DAT_O,
   output logic [3:0]              SEL_O,
   output logic                    WE_O,
   output logic                    STB_O,
   output logic                    CYC_O,
   input  logic [31:0]             DAT_I,
   input  logic                    ACK_I
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   state_t             state_q;
   logic [1:0]         ptr_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic               we_q;
   logic               cyc_q;
   logic [31:0]        adr_q;
   logic [31:0]        dat_q;
   logic [3:0]         sel_q;
   logic [31:0]        rsp_dat_q;
   logic               rsp_err_q;
   logic [CW-1:0]      cnt_q;

   logic               found_d;
   logic [1:0]         win_d;
   logic [1:0]         ptr_d;
   logic               win_we_d;
   logic [31:0]        win_adr_d;
   logic [31:0]        win_dat_d;
   logic [3:0]         win_sel_d;
   int                 scan_idx;

   // First valid requester scanning upward from ptr with wrap-around.
   always_comb begin
      found_d  = 1'b0;
      win_d    = 2'd0;
      scan_idx = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = (int'(ptr_q) + i) % NUM_REQ;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_d && (k == scan_idx) && req_valid_i[k]) begin
               found_d = 1'b1;
               win_d   = 2'(k);
            end
         end
      end
      ptr_d = (int'(win_d) == NUM_REQ - 1) ? 2'd0 : win_d + 2'd1;
   end

   // Grant strobe and winner's request fields.
   always_comb begin
      req_ready_o = '0;
      win_we_d    = 1'b0;
      win_adr_d   = '0;
      win_dat_d   = '0;
      win_sel_d   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_d == 2'(k)) begin
            req_ready_o[k] = (state_q == S_IDLE) && found_d;
            win_we_d       = req_we_i[k];
            win_adr_d      = req_adr_i[32*k +: 32];
            win_dat_d      = req_dat_i[32*k +: 32];
            win_sel_d      = req_sel_i[4*k +: 4];
         end
      end
   end

   // Sequencer FSM; bus registers double as outputs and are zeroed outside BUS.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= 2'd0;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  state_q <= S_BUS;
                  ptr_q   <= ptr_d;
                  grant_q <= req_ready_o;
                  we_q    <= win_we_d;
                  adr_q   <= win_adr_d;
                  dat_q   <= win_dat_d;
                  sel_q   <= win_sel_d;
                  cyc_q   <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            S_BUS: begin
               if (ACK_I || (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
                  // ACK takes priority over an expiry in the same cycle
                  rsp_dat_q   <= (ACK_I && !we_q) ? DAT_I : 32'd0;
                  rsp_err_q   <= !ACK_I;
                  rsp_valid_q <= grant_q;
                  state_q     <= S_RESP;
                  cyc_q       <= 1'b0;
                  we_q        <= 1'b0;
                  adr_q       <= '0;
                  dat_q       <= '0;
                  sel_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RESP: begin
               rsp_valid_q <= '0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign CYC_O       = cyc_q;
   assign STB_O       = cyc_q;
   assign WE_O        = we_q;
   assign ADR_O       = adr_q;
   assign DAT_O       = dat_q;
   assign SEL_O       = sel_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: doc/team_07_wb_master_arbiter.md
# team_07_wb_master_arbiter

Round-robin arbiter and sequencer for the team's single Wishbone master port toward the nebula wishbone arbitrator (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I).
- Shares that port between up to four internal requesters, such as a DMA engine or a framebuffer fetcher.
- Performs one classic single-beat Wishbone cycle per grant.
- Enforces a bus-hang timeout.
- Sits between the team's project logic and the wrapper-level master outputs, which currently tie off to zero.

## Interface
- NUM_REQ, 2, number of requesters (legal 2..4)
- TIMEOUT_CYCLES, 255, max cycles CYC_O stays high without ACK_I (legal 2..65535)
- wb_clk_i  input  1  sole clock, rising edge
- wb_rst_i  input  1  synchronous, active-high reset
- req_valid_i  input  NUM_REQ  per-requester transaction request
- req_we_i  input  NUM_REQ  1 = write, 0 = read
- req_adr_i  input  32*NUM_REQ  address, requester k at bits [32k+31:32k]
- req_dat_i  input  32*NUM_REQ  write data, same packing
- req_sel_i  input  4*NUM_REQ  byte selects, requester k at [4k+3:4k]
- req_ready_o  output  NUM_REQ  one-hot accept strobe (combinational)
- rsp_valid_o  output  NUM_REQ  one-hot, 1-cycle completion strobe
- rsp_dat_o  output  32  read data of completed transaction (shared)
- rsp_err_o  output  1  qualifies rsp_valid_o: 1 = timed out
- busy_o  output  1  high whenever state != IDLE
- ADR_O, DAT_O  output  32 each  Wishbone master address, write data
- SEL_O  output  4  Wishbone byte selects
- WE_O, STB_O, CYC_O  output  1 each  Wishbone master controls
- DAT_I  input  32  Wishbone read data
- ACK_I  input  1  Wishbone acknowledge

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If any req_valid_i is set, the winner is the first set bit scanning upward (with wrap) from ptr.
  - req_ready_o[winner]=1 in that cycle.
  - At the edge: latch winner's we/adr/dat/sel and the winner index, set ptr = (winner+1) mod NUM_REQ, clear the timeout counter, go to BUS.
- BUS:
  - CYC_O=STB_O=1; ADR_O/DAT_O/SEL_O/WE_O come from the latched registers.
  - ACK_I=1 at an edge: capture DAT_I into rsp_dat_o (zero for writes), rsp_err_o=0, go to RESP.
  - Otherwise the counter increments.
  - Counter == TIMEOUT_CYCLES-1 with no ACK_I: rsp_dat_o=0, rsp_err_o=1, go to RESP.
  - ACK_I in the same cycle as expiry: ACK wins, no error.
- RESP: rsp_valid_o[latched index]=1 for one cycle, then IDLE.
- Requester handshake:
  - adr/dat/sel/we must be held stable while valid is high and ready is low.
  - Dropping valid before ready is legal and issues nothing.
  - Only one transaction is outstanding at a time.
- Address/data outputs are driven to zero whenever CYC_O is low.
- ACK_I is ignored outside BUS.
- rsp_dat_o and rsp_err_o hold their last value until the next RESP.
- Counter width is $clog2(TIMEOUT_CYCLES+1).
- Reset values:
  - state = IDLE, ptr = 0.
  - All Wishbone outputs = 0.
  - req_ready_o = 0, rsp_valid_o = 0, rsp_dat_o = 0, rsp_err_o = 0, busy_o = 0.
- Reset mid-transaction: CYC_O/STB_O are low in the cycle after the reset edge and no rsp_valid_o is issued for the aborted transaction.

## Timing
- Cycle N: req_ready_o pulse, accepted at edge N.
- Cycle N+1: CYC_O/STB_O high (all Wishbone outputs registered).
- ACK_I sampled high in cycle M (M ≥ N+1): CYC_O/STB_O low and rsp_valid_o high in M+1; IDLE in M+2, where the next grant's ready may assert.
- Minimum spacing: 3 cycles per transaction (zero-wait-state slave). Accept-to-response: 2 cycles minimum.
- Timeout: CYC_O high for exactly TIMEOUT_CYCLES cycles, then error response the next cycle.
- req_ready_o is combinational from req_valid_i, ptr and state; no other input-to-output combinational path exists.

## Test plan
- Single read, req0 only:
  - Stimulus: req0 adr=0x3000_0010; ACK_I one cycle after CYC_O rises with DAT_I=0xDEAD_BEEF.
  - Required: ready0 in cycle 0; CYC_O in cycles 1-2; rsp_valid_o=01 in cycle 3, rsp_dat_o=0xDEAD_BEEF, rsp_err_o=0.
- Write with byte selects:
  - Stimulus: req1 we=1, adr=0x3000_0004, dat=0x1234_5678, sel=0x3; zero-wait ACK.
  - Required: bus shows those exact values with WE_O=1; rsp_valid_o=10, rsp_dat_o=0.
- Round-robin with NUM_REQ=3:
  - Stimulus: all three valid continuously for 6 transactions.
  - Required: grant order 0,1,2,0,1,2; consecutive ready pulses exactly 3 cycles apart.
- Timeout with TIMEOUT_CYCLES=4, no ACK:
  - Required: CYC_O high exactly 4 cycles; rsp_valid_o with rsp_err_o=1 and rsp_dat_o=0 next cycle; a subsequent request completes normally.
- ACK on expiry cycle:
  - Stimulus: TIMEOUT_CYCLES=4, ACK_I on the 4th CYC cycle with DAT_I=0xA5A5_A5A5.
  - Required: rsp_err_o=0, rsp_dat_o=0xA5A5_A5A5.
- Reset mid-BUS:
  - Stimulus: assert wb_rst_i for 1 cycle while CYC_O is high.
  - Required: all outputs 0 the following cycle, no rsp_valid_o; ptr restored so that req0 wins the next simultaneous 0/1 request.
